// File: rtl/vga_scanout_reader.sv
// VGA timing generator and framebuffer scanout for the 512x512 manycore image.
// Pipeline: counters -> address register -> framebuffer read -> colour/sync output register.
module vga_scanout_reader #(
    parameter int         H_ACTIVE   = 800,
    parameter int         H_FP       = 40,
    parameter int         H_SYNC     = 128,
    parameter int         H_BP       = 88,
    parameter int         V_ACTIVE   = 600,
    parameter int         V_FP       = 1,
    parameter int         V_SYNC     = 4,
    parameter int         V_BP       = 23,
    parameter logic       HS_POL     = 1'b1,
    parameter logic       VS_POL     = 1'b1,
    parameter int         X_OFF      = 144,
    parameter int         Y_OFF      = 44,
    parameter int         RD_LATENCY = 1,
    parameter logic [7:0] BORDER     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    output logic [17:0] o_addr,
    input  logic [7:0]  i_rd_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic        o_frame_start
);
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int PIPE_DEPTH = RD_LATENCY + 1;
    localparam int IMG_SIZE   = 512;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Bit positions of the per-pixel control flags carried alongside the read.
    localparam int F_HS   = 0;
    localparam int F_VS   = 1;
    localparam int F_DE   = 2;
    localparam int F_WIN  = 3;
    localparam int F_FS   = 4;
    localparam int F_BITS = 5;

    logic [HW-1:0] h_cnt_reg;
    logic [HW-1:0] h_cnt_next;
    logic [VW-1:0] v_cnt_reg;
    logic [VW-1:0] v_cnt_next;
    logic          h_wrap;

    always_comb begin
        h_wrap     = (h_cnt_reg == H_LAST);
        h_cnt_next = h_wrap ? '0 : h_cnt_reg + HW'(1);
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // Stage-0 decode straight from the counters.
    int                h_pos;
    int                v_pos;
    logic              active_s0;
    logic              win_s0;
    logic [8:0]        img_x;
    logic [8:0]        img_y;
    logic [17:0]       addr_next;
    logic [F_BITS-1:0] flags_s0;

    always_comb begin
        h_pos     = int'(h_cnt_reg);
        v_pos     = int'(v_cnt_reg);
        active_s0 = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
        win_s0    = active_s0
                    && (h_pos >= X_OFF) && (h_pos < X_OFF + IMG_SIZE)
                    && (v_pos >= Y_OFF) && (v_pos < Y_OFF + IMG_SIZE);
        img_x     = 9'(h_pos - X_OFF);
        img_y     = 9'(v_pos - Y_OFF);

        addr_next = '0;
        if (win_s0) begin
            addr_next = {img_y[8:6], img_x[8:6], img_y[5:0], img_x[5:0]};
        end

        flags_s0         = '0;
        flags_s0[F_HS]   = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
        flags_s0[F_VS]   = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
        flags_s0[F_DE]   = active_s0;
        flags_s0[F_WIN]  = win_s0;
        flags_s0[F_FS]   = (h_pos == 0) && (v_pos == 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_addr <= '0;
        end else begin
            o_addr <= addr_next;
        end
    end

    // Flags ride a shift pipeline matching address register plus memory latency,
    // so they arrive at the output register together with i_rd_data.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_pipe
            logic [F_BITS-1:0] flags_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset) begin
                        flags_reg <= '0;
                    end else begin
                        flags_reg <= flags_s0;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (reset) begin
                        flags_reg <= '0;
                    end else begin
                        flags_reg <= g_pipe[gi-1].flags_reg;
                    end
                end
            end
        end
    endgenerate

    logic [F_BITS-1:0] flags_d;
    logic [7:0]        src_byte;
    logic              show_pixel;

    always_comb begin
        flags_d    = g_pipe[PIPE_DEPTH-1].flags_reg;
        src_byte   = flags_d[F_WIN] ? i_rd_data : BORDER;
        show_pixel = flags_d[F_DE] && i_enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
        end else begin
            o_hsync       <= flags_d[F_HS] ? HS_POL : ~HS_POL;
            o_vsync       <= flags_d[F_VS] ? VS_POL : ~VS_POL;
            o_de          <= flags_d[F_DE];
            o_frame_start <= flags_d[F_FS];
            if (show_pixel) begin
                // RGB332 -> RGB444 by replicating the top bits into the LSBs.
                o_r <= {src_byte[7:5], src_byte[7]};
                o_g <= {src_byte[4:2], src_byte[4]};
                o_b <= {src_byte[1:0], src_byte[1:0]};
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: compact timing, random framebuffer contents and
// enable toggling, checked every cycle against a raster-position model.
module tb_vga_scanout_reader;
    localparam int         H_ACTIVE   = 528;
    localparam int         H_FP       = 4;
    localparam int         H_SYNC     = 8;
    localparam int         H_BP       = 4;
    localparam int         V_ACTIVE   = 68;
    localparam int         V_FP       = 2;
    localparam int         V_SYNC     = 3;
    localparam int         V_BP       = 3;
    localparam logic       HS_POL     = 1'b1;
    localparam logic       VS_POL     = 1'b0;
    localparam int         X_OFF      = 8;
    localparam int         Y_OFF      = 2;
    localparam int         RD_LATENCY = 1;
    localparam logic [7:0] BORDER     = 8'hB6;

    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 544
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 76
    localparam int FRAME    = HT * VT;                           // 41344
    localparam int D        = RD_LATENCY + 2;
    localparam int RST_AT   = FRAME + 10 * HT + 300;
    localparam int POST_LEN = 2400;
    localparam int MAX_CYC  = RST_AT + POST_LEN + 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [17:0] o_addr;
    logic [7:0]  i_rd_data;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic        o_frame_start;

    vga_scanout_reader #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
        .RD_LATENCY(RD_LATENCY), .BORDER(BORDER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_enable(i_enable),
        .o_addr(o_addr),
        .i_rd_data(i_rd_data),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_de(o_de),
        .o_r(o_r),
        .o_g(o_g),
        .o_b(o_b),
        .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:262143];
    int          checks   = 0;
    int          failures = 0;
    int          n_cur    = 0;
    logic        en_prev  = 1'b1;
    logic [17:0] addr_prev = '0;

    // Pixel (h, v) of the raster, assuming it lies inside the image window.
    function automatic int img_addr(int h, int v);
        int ix = h - X_OFF;
        int iy = v - Y_OFF;
        return (iy / 64) * 32768 + (ix / 64) * 4096 + (iy % 64) * 64 + (ix % 64);
    endfunction

    function automatic bit in_win(int h, int v);
        return (h < H_ACTIVE) && (v < V_ACTIVE) && (h >= X_OFF) && (h < X_OFF + 512)
               && (v >= Y_OFF) && (v < Y_OFF + 512);
    endfunction

    function automatic logic [11:0] expand(int d);
        int r = 2 * (d / 32) + d / 128;
        int g = 2 * ((d / 4) % 8) + (d / 16) % 2;
        int b = 5 * (d % 4);
        return 12'(r * 256 + g * 16 + b);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, n_cur, act, exp);
        end
    endtask

    task automatic model_check();
        int          k;
        int          h;
        int          v;
        bit          act;
        bit          hs;
        bit          vs;
        bit          fs;
        int          pix;
        logic [11:0] rgb;
        logic [31:0] e_addr;
        logic [15:0] e_vid;
        logic [15:0] a_vid;

        e_addr = 32'd0;
        if (n_cur >= 1) begin
            k = n_cur - 1;
            h = k % HT;
            v = (k / HT) % VT;
            if (in_win(h, v)) e_addr = 32'(img_addr(h, v));
        end

        if (n_cur < D) begin
            e_vid = {~HS_POL, ~VS_POL, 1'b0, 1'b0, 12'h000};
        end else begin
            k   = n_cur - D;
            h   = k % HT;
            v   = (k / HT) % VT;
            act = (h < H_ACTIVE) && (v < V_ACTIVE);
            hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
            vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
            fs  = (h == 0) && (v == 0);
            pix = in_win(h, v) ? int'(mem[img_addr(h, v)]) : int'(BORDER);
            rgb = (act && en_prev) ? expand(pix) : 12'h000;
            e_vid = {hs ? HS_POL : ~HS_POL, vs ? VS_POL : ~VS_POL, act, fs, rgb};
        end

        a_vid = {o_hsync, o_vsync, o_de, o_frame_start, o_r, o_g, o_b};
        cmp("addr", 32'(o_addr), e_addr);
        cmp("video", 32'(a_vid), 32'(e_vid));
    endtask

    initial begin
        int  stage;
        int  cnt;
        bit  done;
        logic [11:0] lit_rgb [0:3];

        lit_rgb[0] = 12'hF00;
        lit_rgb[1] = 12'h0F0;
        lit_rgb[2] = 12'h00F;
        lit_rgb[3] = 12'h99A;

        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;
        mem[1] = 8'h1C;
        mem[2] = 8'h03;
        mem[3] = 8'h92;

        reset     = 1'b1;
        i_enable  = 1'b1;
        i_rd_data = 8'h00;
        stage     = 0;
        cnt       = 0;
        done      = 1'b0;

        for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (reset) n_cur = 0;
            else n_cur++;
            en_prev   = i_enable;
            i_rd_data = mem[addr_prev];
            addr_prev = o_addr;

            model_check();

            if (stage == 1 || stage == 3) begin
                if (n_cur == 3) cmp("frame_start_first", 32'(o_frame_start), 32'd1);
                if (n_cur == 534) cmp("hsync_before", 32'(o_hsync), 32'd0);
                if (n_cur == 535) cmp("hsync_rise", 32'(o_hsync), 32'd1);
                if (n_cur == 542) cmp("hsync_last", 32'(o_hsync), 32'd1);
                if (n_cur == 543) cmp("hsync_fall", 32'(o_hsync), 32'd0);
                if (n_cur >= 1099 && n_cur <= 1102)
                    cmp("rgb_literal", 32'({o_r, o_g, o_b}), 32'(lit_rgb[n_cur - 1099]));
                if (n_cur == 1642) cmp("border_left", 32'({o_r, o_g, o_b}), 32'h00000BBA);
                if (n_cur == 2155) cmp("border_right", 32'({o_r, o_g, o_b}), 32'h00000BBA);
            end
            if (stage == 1) begin
                if (n_cur == 1097) cmp("addr_origin", 32'(o_addr), 32'h00000);
                if (n_cur == 28497) cmp("addr_200_50", 32'(o_addr), 32'h03C88);
                if (n_cur == 36424) cmp("addr_511_64", 32'(o_addr), 32'h0F03F);
                if (n_cur == 2165) cmp("blank_rgb_de", 32'({o_de, o_r, o_g, o_b}), 32'h0);
                if (n_cur == 10981) cmp("enable_off", 32'({o_de, o_r, o_g, o_b}), 32'h1000);
                if (n_cur == 38082) cmp("vsync_before", 32'(o_vsync), 32'd1);
                if (n_cur == 38083) cmp("vsync_start", 32'(o_vsync), 32'd0);
                if (n_cur == 39714) cmp("vsync_last", 32'(o_vsync), 32'd0);
                if (n_cur == 39715) cmp("vsync_end", 32'(o_vsync), 32'd1);
                if (n_cur == FRAME + 2) cmp("frame_start_pre", 32'(o_frame_start), 32'd0);
                if (n_cur == FRAME + 3) cmp("frame_start_repeat", 32'(o_frame_start), 32'd1);
            end

            case (stage)
                0: begin
                    cnt++;
                    if (cnt == 5) begin
                        reset = 1'b0;
                        stage = 1;
                    end
                end
                1: begin
                    if (n_cur == RST_AT) begin
                        reset    = 1'b1;
                        i_enable = 1'b1;
                        stage    = 2;
                        cnt      = 0;
                    end else if (n_cur == 10980) begin
                        i_enable = 1'b0;
                    end else if (n_cur == 11000) begin
                        i_enable = 1'b1;
                    end else if (n_cur >= FRAME) begin
                        if (i_enable) begin
                            if ($urandom_range(0, 399) == 0) i_enable = 1'b0;
                        end else if ($urandom_range(0, 39) == 0) begin
                            i_enable = 1'b1;
                        end
                    end
                end
                2: begin
                    cnt++;
                    if (cnt == 1) begin
                        cmp("reset_state",
                            32'({o_addr, o_hsync, o_vsync, o_de, o_frame_start, o_r, o_g, o_b}),
                            32'({18'h0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 12'h000}));
                    end
                    if (cnt == 2) begin
                        reset = 1'b0;
                        stage = 3;
                    end
                end
                default: begin
                    if (n_cur >= POST_LEN) done = 1'b1;
                end
            endcase

            if (failures >= 50) done = 1'b1;
        end

        if (!done) begin
            failures++;
            $display("FAIL run_bound cycle=%0d actual=stage%0d required=stage3", n_cur, stage);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
